// File: rtl/lpc_tx_fifo.sv
// rtl/lpc_tx_fifo.sv - LPC-to-UART byte FIFO with busy-paced drain FSM
// Optional dropped-write counter enabled by defining LPC_TX_FIFO_OVF_CNT_EN.
module lpc_tx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int WIDTH        = 8,
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic                  LPC_CLK,
  input  logic                  LPC_RST,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_full,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [7:0]            ovf_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SENT,
    ST_WAIT
  } state_t;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                overflow_q, overflow_d;
  logic                empty, push, drop, pop;

  // Extra pointer bit distinguishes full from empty; level can never exceed DEPTH.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign in_full = (level == {1'b1, {DEPTH_LOG2{1'b0}}});
  assign push    = in_valid && !in_full;
  assign drop    = in_valid && in_full;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    out_valid_d = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && !out_busy) begin
          state_d     = ST_SENT;
          out_valid_d = 1'b1;
          pop         = 1'b1;
          timer_d     = '0;
        end
      end
      ST_SENT: begin
        // Timeout guards against a uart that never acknowledges with busy.
        if (out_busy) begin
          state_d = ST_WAIT;
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (!out_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    out_data_d = pop  ? mem_q[rd_ptr_q[DEPTH_LOG2-1:0]] : out_data_q;
    overflow_d = overflow_q || drop;
  end

  always_ff @(posedge LPC_CLK) begin
    if (!LPC_RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge LPC_CLK) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

`ifdef LPC_TX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge LPC_CLK) begin
    if (!LPC_RST) begin
      ovf_cnt_q <= 8'h00;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = 8'h00;
`endif

endmodule
